// File: rtl/nano_pkg.sv
// Shared definitions for the nanoprocessor.
//   opcode_t      : 4-bit instruction opcode, also consumed by the decoder stage.
//   fetch_state_t : sequencing states of the fetch stage.
//   INSTR_BYTES   : every instruction occupies two bytes (opcode byte, operand byte).
package nano_pkg;

    typedef enum logic [3:0] {
        op_nop = 4'd0,
        op_xor = 4'd1,
        op_and = 4'd2,
        op_or  = 4'd3,
        op_add = 4'd4,
        op_adc = 4'd5,
        op_sub = 4'd6,
        op_sbc = 4'd7,
        op_rol = 4'd8,
        op_ror = 4'd9,
        op_lda = 4'd10,
        op_sta = 4'd11,
        op_out = 4'd12,
        op_jmp = 4'd13,
        op_jnc = 4'd14,
        op_jnz = 4'd15
    } opcode_t;

    typedef enum logic [2:0] {
        st_if1 = 3'd0,
        st_if2 = 3'd1,
        st_if3 = 3'd2,
        st_ex  = 3'd3,
        st_wb  = 3'd4
    } fetch_state_t;

    localparam int INSTR_BYTES = 2;

endpackage

// File: rtl/nano_fetch_if.sv
// Bus between the fetch stage and its surroundings (memory, ALU flags, decoder).
//   run       : run enable
//   mem_addr  : memory address, mem_rdata valid the following cycle
//   mem_rdata : memory read data
//   mem_we    : memory write strobe (STA)
//   carry/zero: registered ALU flags
//   I         : current opcode
//   operand   : current operand byte
//   exec      : one-cycle execute pulse
//   load_en   : one-cycle pulse, mem_rdata holds LDA data
//   pc        : program counter (trace)
// master = fetch stage, slave = environment.
interface nano_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              run;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;
    logic              carry;
    logic              zero;
    logic [3:0]        I;
    logic [DATA_W-1:0] operand;
    logic              exec;
    logic              load_en;
    logic [ADDR_W-1:0] pc;

    modport master (
        input  run, mem_rdata, carry, zero,
        output mem_addr, mem_we, I, operand, exec, load_en, pc
    );

    modport slave (
        output run, mem_rdata, carry, zero,
        input  mem_addr, mem_we, I, operand, exec, load_en, pc
    );
endinterface

// File: rtl/nano_fetch.sv
// Instruction fetch and sequencing stage of the nanoprocessor.
// Walks the PC, reads the two-byte instruction from synchronous memory,
// latches opcode and operand, pulses exec, resolves JMP/JNC/JNZ and drives
// the memory address and strobes for LDA/STA.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : nano_fetch_if master modport (memory, flags, run, decoded outputs)
module nano_fetch #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    nano_fetch_if.master  bus
);
    import nano_pkg::*;

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    opcode_t           i_reg;
    logic [DATA_W-1:0] operand_reg;

    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] pc_plus2;
    logic [ADDR_W-1:0] target;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              exec;
    logic              load_en;

    // Both increments wrap naturally at the address width.
    assign pc_plus1 = pc_reg + ADDR_W'(1);
    assign pc_plus2 = pc_reg + ADDR_W'(INSTR_BYTES);
    assign target   = operand_reg[ADDR_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= st_if1;
            pc_reg      <= '0;
            i_reg       <= op_nop;
            operand_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            // Memory answers one cycle after the address: the opcode byte
            // requested in IF1 arrives during IF2, the operand during IF3.
            if (state_reg == st_if2) begin
                i_reg <= opcode_t'(bus.mem_rdata[DATA_W-1 -: 4]);
            end
            if (state_reg == st_if3) begin
                operand_reg <= bus.mem_rdata;
            end
        end
    end

    // Strobes are decoded from the registered state only, so each is a clean
    // single-cycle pulse and drops the moment reset forces the state to IF1.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        mem_addr   = pc_reg;
        mem_we     = 1'b0;
        exec       = 1'b0;
        load_en    = 1'b0;
        case (state_reg)
            st_if1: begin
                if (bus.run) begin
                    state_next = st_if2;
                end
            end
            st_if2: begin
                mem_addr   = pc_plus1;
                state_next = st_if3;
            end
            st_if3: begin
                mem_addr   = pc_plus1;
                state_next = st_ex;
            end
            st_ex: begin
                mem_addr = target;
                exec     = 1'b1;
                mem_we   = (i_reg == op_sta);
                // Flags are looked at only here, on the EX edge.
                case (i_reg)
                    op_jmp:  pc_next = target;
                    op_jnc:  pc_next = bus.carry ? pc_plus2 : target;
                    op_jnz:  pc_next = bus.zero  ? pc_plus2 : target;
                    default: pc_next = pc_plus2;
                endcase
                state_next = (i_reg == op_lda) ? st_wb : st_if1;
            end
            st_wb: begin
                mem_addr   = target;
                load_en    = 1'b1;
                state_next = st_if1;
            end
            default: begin
                state_next = st_if1;
            end
        endcase
    end

    assign bus.mem_addr = mem_addr;
    assign bus.mem_we   = mem_we;
    assign bus.exec     = exec;
    assign bus.load_en  = load_en;
    assign bus.I        = i_reg;
    assign bus.operand  = operand_reg;
    assign bus.pc       = pc_reg;

endmodule

// File: tb/tb_nano_fetch.sv
// Self-checking bench for nano_fetch: an instruction-level trace model plus
// directed literal checks from the test plan, then a randomized program run.
module tb_nano_fetch;

    logic clk;
    logic reset;

    nano_fetch_if #(.ADDR_W(8), .DATA_W(8)) bus();

    nano_fetch #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous memory: data valid the cycle after the address.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    int vectors = 0;
    int errors  = 0;

    bit rand_mode   = 1'b0;
    bit force_run   = 1'b0;
    bit force_carry = 1'b0;
    bit force_zero  = 1'b0;

    // One expected cycle of an in-flight instruction.
    typedef struct {
        logic [7:0] addr;
        bit         we;
        bit         ex;
        bit         ld;
        logic [3:0] i;
        logic [7:0] op;
        bit         is_ex;
    } cyc_t;

    cyc_t       q[$];
    logic [7:0] m_pc = 8'h00;
    logic [3:0] m_i  = 4'h0;
    logic [7:0] m_op = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Compare + drive process: at every falling edge check the DUT against the
    // model, choose the inputs for the next rising edge, then advance the model.
    initial begin
        cyc_t        e;
        cyc_t        c;
        logic [30:0] act;
        logic [30:0] expv;
        logic [7:0]  p1;
        logic [7:0]  p2;
        logic [7:0]  opv;
        logic [3:0]  opc;
        forever begin
            @(negedge clk);
            if (reset) begin
                q.delete();
                m_pc = 8'h00;
                m_i  = 4'h0;
                m_op = 8'h00;
            end
            if (q.size() == 0) begin
                e.addr = m_pc; e.we = 0; e.ex = 0; e.ld = 0;
                e.i = m_i; e.op = m_op; e.is_ex = 0;
            end else begin
                e = q[0];
            end
            act  = {bus.mem_addr, bus.mem_we, bus.exec, bus.load_en, bus.I, bus.operand, bus.pc};
            expv = {e.addr, e.we, e.ex, e.ld, e.i, e.op, m_pc};
            vectors++;
            if (act !== expv) begin
                errors++;
                $display("FAIL trace t=%0t: got addr=%h we=%b exec=%b ld=%b I=%h op=%h pc=%h, required addr=%h we=%b exec=%b ld=%b I=%h op=%h pc=%h",
                         $time, bus.mem_addr, bus.mem_we, bus.exec, bus.load_en, bus.I, bus.operand, bus.pc,
                         e.addr, e.we, e.ex, e.ld, e.i, e.op, m_pc);
            end

            if (rand_mode) begin
                bus.run   = ($urandom_range(0, 3) != 0);
                bus.carry = $urandom_range(0, 1) == 1;
                bus.zero  = $urandom_range(0, 1) == 1;
            end else begin
                bus.run   = force_run;
                bus.carry = force_carry;
                bus.zero  = force_zero;
            end

            if (!reset) begin
                if (q.size() == 0) begin
                    if (bus.run) begin
                        // Launch: lay out the remaining cycles of this instruction.
                        p1  = m_pc + 8'd1;
                        opc = mem[m_pc][7:4];
                        opv = mem[p1];
                        c.we = 0; c.ex = 0; c.ld = 0; c.is_ex = 0;
                        c.addr = p1; c.i = m_i; c.op = m_op;
                        q.push_back(c);
                        c.i = opc;
                        q.push_back(c);
                        c.addr = opv; c.op = opv; c.ex = 1; c.is_ex = 1;
                        c.we = (opc == 4'd11);
                        q.push_back(c);
                        if (opc == 4'd10) begin
                            c.ex = 0; c.is_ex = 0; c.we = 0; c.ld = 1;
                            q.push_back(c);
                        end
                        m_i  = opc;
                        m_op = opv;
                    end
                end else begin
                    c = q.pop_front();
                    if (c.is_ex) begin
                        p2 = m_pc + 8'd2;
                        case (c.i)
                            4'd13:   m_pc = c.op;
                            4'd14:   m_pc = bus.carry ? p2 : c.op;
                            4'd15:   m_pc = bus.zero  ? p2 : c.op;
                            default: m_pc = p2;
                        endcase
                    end
                end
            end
        end
    end

    int cur = 0;

    task automatic release_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        #1 cur = 0;
    endtask

    task automatic start_test(input bit r, input bit c, input bit z);
        reset       = 1'b1;
        force_run   = r;
        force_carry = c;
        force_zero  = z;
        @(posedge clk);
        release_reset();
    endtask

    task automatic to_cycle(input int k);
        repeat (k - cur) @(posedge clk);
        #3 cur = k;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    endtask

    initial begin
        reset = 1'b1;
        clear_mem();

        // ADD 0x12 then JMP 0x00.
        mem[0] = 8'h40; mem[1] = 8'h12; mem[2] = 8'hD0; mem[3] = 8'h00;
        start_test(1, 0, 0);
        chk("reset_addr", bus.mem_addr, 8'h00);
        chk("reset_I", bus.I, 4'h0);
        to_cycle(1); chk("if2_addr", bus.mem_addr, 8'h01);
        to_cycle(2); chk("I_at_2", bus.I, 4'h4);
        to_cycle(3); chk("operand_at_3", bus.operand, 8'h12);
        chk("exec_at_3", bus.exec, 1'b1);
        to_cycle(4); chk("pc_at_4", bus.pc, 8'h02);
        chk("exec_at_4", bus.exec, 1'b0);
        to_cycle(8); chk("jmp_pc_at_8", bus.pc, 8'h00);

        // JNC / JNZ at 0x10 with operand 0x40; the unrelated flag is inverted.
        for (int k = 0; k < 4; k++) begin
            bit jnz;
            bit flag;
            jnz  = (k >= 2);
            flag = (k % 2) == 1;
            clear_mem();
            mem[8'h00] = 8'hD0; mem[8'h01] = 8'h10;
            mem[8'h10] = jnz ? 8'hF0 : 8'hE0; mem[8'h11] = 8'h40;
            if (jnz) start_test(1, !flag, flag);
            else     start_test(1, flag, !flag);
            to_cycle(4); chk("branch_pc_at_4", bus.pc, 8'h10);
            to_cycle(8); chk(jnz ? "jnz_target" : "jnc_target", bus.pc, flag ? 8'h12 : 8'h40);
        end

        // STA 0x80.
        clear_mem();
        mem[0] = 8'hB0; mem[1] = 8'h80;
        start_test(1, 0, 0);
        to_cycle(2); chk("sta_we_if3", bus.mem_we, 1'b0);
        to_cycle(3); chk("sta_we_ex", bus.mem_we, 1'b1);
        chk("sta_addr_ex", bus.mem_addr, 8'h80);
        to_cycle(4); chk("sta_we_after", bus.mem_we, 1'b0);
        chk("sta_addr_after", bus.mem_addr, 8'h02);

        // Reset asserted during EX of the STA.
        start_test(1, 0, 0);
        to_cycle(3); chk("sta2_we_ex", bus.mem_we, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst_we", bus.mem_we, 1'b0);
        chk("rst_exec", bus.exec, 1'b0);
        chk("rst_addr", bus.mem_addr, 8'h00);
        chk("rst_I", bus.I, 4'h0);
        chk("rst_operand", bus.operand, 8'h00);
        chk("rst_pc", bus.pc, 8'h00);
        release_reset();
        chk("restart_addr", bus.mem_addr, 8'h00);
        to_cycle(2); chk("restart_I", bus.I, 4'hB);
        to_cycle(3); chk("restart_we", bus.mem_we, 1'b1);

        // LDA 0x33.
        clear_mem();
        mem[0] = 8'hA0; mem[1] = 8'h33;
        start_test(1, 0, 0);
        to_cycle(3); chk("lda_exec", bus.exec, 1'b1);
        chk("lda_ld_ex", bus.load_en, 1'b0);
        to_cycle(4); chk("lda_ld_wb", bus.load_en, 1'b1);
        chk("lda_addr_wb", bus.mem_addr, 8'h33);
        to_cycle(5); chk("lda_next_addr", bus.mem_addr, 8'h02);
        chk("lda_ld_after", bus.load_en, 1'b0);

        // run held low.
        clear_mem();
        mem[0] = 8'h40; mem[1] = 8'h12;
        start_test(0, 0, 0);
        to_cycle(5); chk("stall_pc", bus.pc, 8'h00);
        chk("stall_addr", bus.mem_addr, 8'h00);
        chk("stall_I", bus.I, 4'h0);
        force_run = 1'b1;
        to_cycle(7); chk("unstall_I", bus.I, 4'h4);

        // PC wrap: JMP 0xFF, NOP at 0xFF takes its operand from 0x00.
        clear_mem();
        mem[8'h00] = 8'hD0; mem[8'h01] = 8'hFF; mem[8'hFF] = 8'h00;
        start_test(1, 0, 0);
        to_cycle(4); chk("wrap_pc", bus.pc, 8'hFF);
        to_cycle(5); chk("wrap_addr", bus.mem_addr, 8'h00);
        to_cycle(7); chk("wrap_operand", bus.operand, 8'hD0);
        to_cycle(8); chk("wrap_next_pc", bus.pc, 8'h01);

        // Random programs, random run and flags, checked by the trace model.
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 255));
        rand_mode = 1'b1;
        start_test(1, 0, 0);
        repeat (3000) @(posedge clk);
        #3;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
